// File: rtl/usb_video_frame_sink_if.sv
// Bundles the USB write-side stream, display vblank and frame-RAM write port of the video sink.
interface usb_video_frame_sink_if #(
    parameter int unsigned ADDR_W = 15
);
    logic [2:0]      usb_trans_type;
    logic            usb_wr;
    logic [31:0]     usb_wr_data;
    logic            usb_wr_ready;
    logic            disp_vblank;
    logic            fb_we;
    logic [ADDR_W:0] fb_waddr;
    logic [31:0]     fb_wdata;
    logic            front_bank;
    logic            frame_done;
    logic [7:0]      abort_cnt;

    modport master (
        output usb_trans_type, usb_wr, usb_wr_data, disp_vblank,
        input  usb_wr_ready, fb_we, fb_waddr, fb_wdata, front_bank, frame_done, abort_cnt
    );

    modport slave (
        input  usb_trans_type, usb_wr, usb_wr_data, disp_vblank,
        output usb_wr_ready, fb_we, fb_waddr, fb_wdata, front_bank, frame_done, abort_cnt
    );
endinterface

// File: rtl/usb_video_frame_sink.sv
// Writes V_BUFFER transfers into the back bank of a double-buffered frame RAM and swaps
// banks at the first display vblank after a complete transfer.
module usb_video_frame_sink #(
    parameter int unsigned FB_WORDS   = 19200,
    parameter int unsigned XFER_WORDS = 32768,
    parameter int unsigned ADDR_W     = 15
) (
    input logic                   clk,
    input logic                   rst,
    usb_video_frame_sink_if.slave bus
);
    localparam int unsigned CntW = ADDR_W + 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(XFER_WORDS - 1);
    localparam logic [CntW-1:0] FbWords = CntW'(FB_WORDS);

    typedef enum logic [1:0] {StIdle, StRecv, StSwapWait} state_e;

    state_e            state;
    logic [CntW-1:0]   word_cnt;
    logic              front_bank;
    logic              frame_done;
    logic [7:0]        abort_cnt;
    logic              fb_we;
    logic [ADDR_W:0]   fb_waddr;
    logic [31:0]       fb_wdata;

    logic              is_vbuf;
    logic              wr_ready;
    logic              accept;
    logic [CntW-1:0]   idx;

    assign is_vbuf  = bus.usb_trans_type == 3'b010;
    assign wr_ready = ((state == StIdle) || (state == StRecv)) && is_vbuf;
    assign accept   = bus.usb_wr && wr_ready;
    // The word accepted in IDLE is always index 0.
    assign idx      = (state == StIdle) ? '0 : word_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            word_cnt   <= '0;
            front_bank <= 1'b0;
            frame_done <= 1'b0;
            abort_cnt  <= '0;
            fb_we      <= 1'b0;
            fb_waddr   <= '0;
            fb_wdata   <= '0;
        end else begin
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            if (accept) begin
                fb_we    <= idx < FbWords;
                fb_waddr <= {~front_bank, idx[ADDR_W-1:0]};
                fb_wdata <= bus.usb_wr_data;
            end
            unique case (state)
                StIdle: begin
                    word_cnt <= '0;
                    if (accept) begin
                        word_cnt <= CntW'(1);
                        state    <= StRecv;
                    end
                end
                StRecv: begin
                    if (!is_vbuf) begin
                        state    <= StIdle;
                        word_cnt <= '0;
                        if (abort_cnt != 8'hff) abort_cnt <= abort_cnt + 8'd1;
                    end else if (accept) begin
                        if (word_cnt == LastIdx) begin
                            state    <= StSwapWait;
                            word_cnt <= '0;
                        end else begin
                            word_cnt <= word_cnt + CntW'(1);
                        end
                    end
                end
                StSwapWait: begin
                    // Entered on the last-word edge, so a coincident vblank is never seen here.
                    if (bus.disp_vblank) begin
                        front_bank <= ~front_bank;
                        frame_done <= 1'b1;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.usb_wr_ready = wr_ready;
    assign bus.fb_we        = fb_we;
    assign bus.fb_waddr     = fb_waddr;
    assign bus.fb_wdata     = fb_wdata;
    assign bus.front_bank   = front_bank;
    assign bus.frame_done   = frame_done;
    assign bus.abort_cnt    = abort_cnt;
endmodule

// File: tb/tb_usb_video_frame_sink.sv
// Randomised bench for usb_video_frame_sink: a transfer-level model predicts every output each cycle.
module tb_usb_video_frame_sink;
    localparam int unsigned FB = 150;
    localparam int unsigned XF = 256;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_video_frame_sink_if #(.ADDR_W(AW)) vif ();

    usb_video_frame_sink #(
        .FB_WORDS(FB),
        .XFER_WORDS(XF),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words accepted so far in the current transfer, and whether a full frame awaits vblank.
    bit          m_valid = 0;
    bit          m_front, m_full, e_we, e_done;
    int          m_cnt, m_abort;
    logic [AW:0] e_addr;
    logic [31:0] e_data;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_front = 0; m_full = 0; m_cnt = 0; m_abort = 0;
            e_we = 0; e_done = 0;
        end else if (m_valid) begin
            e_we = 0; e_done = 0;
            if (m_full) begin
                if (vif.disp_vblank) begin
                    m_front = ~m_front; m_full = 0; e_done = 1;
                end
            end else if (m_cnt > 0 && vif.usb_trans_type != 3'b010) begin
                m_cnt = 0;
                if (m_abort < 255) m_abort++;
            end else if (vif.usb_wr && vif.usb_trans_type == 3'b010) begin
                if (m_cnt < FB) begin
                    e_we = 1; e_addr = {~m_front, AW'(m_cnt)}; e_data = vif.usb_wr_data;
                end
                m_cnt++;
                if (m_cnt == XF) begin
                    m_cnt = 0; m_full = 1;
                end
            end
        end
    end

    int wr_seen = 0, done_seen = 0;
    bit first_pending = 0;
    logic [AW:0] first_addr;

    always @(negedge clk) begin
        if (m_valid) begin
            check("fb_we", vif.fb_we, e_we);
            if (e_we) begin
                check("fb_waddr", vif.fb_waddr, e_addr);
                check("fb_wdata", vif.fb_wdata, e_data);
            end
            check("frame_done", vif.frame_done, e_done);
            check("front_bank", vif.front_bank, m_front);
            check("abort_cnt", vif.abort_cnt, m_abort);
            check("usb_wr_ready", vif.usb_wr_ready,
                  !m_full && vif.usb_trans_type == 3'b010);
            if (vif.fb_we === 1'b1) begin
                wr_seen++;
                if (first_pending) begin first_addr = vif.fb_waddr; first_pending = 0; end
            end
            if (vif.frame_done === 1'b1) done_seen++;
        end
    end

    task automatic do_reset();
        rst = 1; vif.usb_trans_type = 3'b000; vif.usb_wr = 0; vif.usb_wr_data = '0;
        vif.disp_vblank = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // Push n words with random idle gaps and ignored random vblanks.
    task automatic send(input int n, input bit idx_data, input bit vb_last, output int acc);
        int budget = 0;
        acc = 0;
        while (acc < n) begin
            if (budget > 8 * n + 50) begin
                total++; bad++;
                $display("FAIL send_timeout: got %0d words want %0d", acc, n);
                break;
            end
            budget++;
            @(posedge clk); #1;
            vif.usb_trans_type = 3'b010;
            vif.usb_wr = ($urandom_range(0, 3) != 0);
            vif.usb_wr_data = idx_data ? 32'(acc) : $urandom;
            if (vb_last) vif.disp_vblank = vif.usb_wr && (acc == n - 1);
            else         vif.disp_vblank = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            if (vif.usb_wr && vif.usb_wr_ready) acc++;
        end
        @(posedge clk); #1;
        vif.usb_wr = 0; vif.disp_vblank = 0;
    endtask

    task automatic vblank_pulse();
        @(posedge clk); #1 vif.disp_vblank = 1;
        @(posedge clk); #1 vif.disp_vblank = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, stalled, d0;

        do_reset();
        check("rst_fb_we", vif.fb_we, 0);
        check("rst_fb_waddr", vif.fb_waddr, 0);
        check("rst_fb_wdata", vif.fb_wdata, 0);
        check("rst_front", vif.front_bank, 0);
        check("rst_done", vif.frame_done, 0);
        check("rst_abort", vif.abort_cnt, 0);
        check("rst_ready", vif.usb_wr_ready, 0);

        // Frame 1: data = index, lands in bank 1
        wr_seen = 0; first_pending = 1;
        send(XF, 1, 0, acc);
        idle(3);
        check("f1_writes", wr_seen, FB);
        check("f1_first_addr", first_addr, 9'h100);
        check("f1_no_swap_yet", vif.front_bank, 0);
        d0 = done_seen;
        vblank_pulse();
        idle(2);
        check("f1_front", vif.front_bank, 1);
        check("f1_done_pulses", done_seen - d0, 1);

        // Frame 2: bank 0
        first_pending = 1;
        send(XF, 0, 0, acc);
        check("f2_first_addr", first_addr, 9'h000);
        vblank_pulse();
        idle(1);
        check("f2_front", vif.front_bank, 0);

        // Frame 3 then a stalled attempt at the next frame
        send(XF, 0, 0, acc);
        stalled = 0;
        repeat (20) begin
            @(posedge clk); #1;
            vif.usb_wr = 1; vif.usb_wr_data = $urandom;
            @(negedge clk);
            if (vif.usb_wr_ready) stalled++;
        end
        @(posedge clk); #1 vif.usb_wr = 0;
        check("f3_stall_accepts", stalled, 0);
        vblank_pulse();
        idle(1);
        check("f3_front", vif.front_bank, 1);

        // Abort after 100 words
        send(100, 0, 0, acc);
        vif.usb_trans_type = 3'b100;
        idle(3);
        check("abort_cnt_1", vif.abort_cnt, 1);
        check("abort_front", vif.front_bank, 1);
        first_pending = 1;
        send(XF, 0, 0, acc);
        check("abort_restart_addr", first_addr, 9'h000);
        vblank_pulse();
        idle(1);
        check("f4_front", vif.front_bank, 0);

        // vblank coincident with the last word is not honoured
        send(XF, 0, 1, acc);
        idle(4);
        check("coincident_no_swap", vif.front_bank, 0);
        vblank_pulse();
        idle(1);
        check("coincident_later_swap", vif.front_bank, 1);

        // Reset mid-frame
        d0 = done_seen;
        send(50, 0, 0, acc);
        do_reset();
        check("midrst_front", vif.front_bank, 0);
        check("midrst_fb_we", vif.fb_we, 0);
        check("midrst_abort", vif.abort_cnt, 0);
        idle(3);
        check("midrst_no_done", done_seen - d0, 0);

        // abort_cnt saturates at 255
        for (int k = 0; k < 260; k++) begin
            send(1, 0, 0, acc);
            vif.usb_trans_type = 3'b011;
            idle(1);
        end
        idle(2);
        check("abort_saturate", vif.abort_cnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
